dl_reg_en_arb: RTL and testbench
================================

// Module: dl_reg_en_arb
// PURPOSE
//   Round-robin write arbiter for one shared enabled register of width NUM_BITS.
//   Up to NUM_REQ requesters compete to write it; at most one wins per cycle.
//   The winner's data is captured at the next clock edge.
//   Used wherever several pipeline agents update a single shared status/CSR-style register.
// PARAMETERS
//   NUM_BITS  32  width of the shared register and of each write-data lane
//   NUM_REQ   4   number of requesters (>=2)
//   IDX_W     $clog2(NUM_REQ)  width of requester index (derived, not overridden)
// PORTS
//   clk    in   1                 clock; all state updates on posedge
//   rst    in   1                 synchronous, active-high reset
//   req    in   NUM_REQ           req[i]=1: requester i wants to write this cycle
//   wdata  in   NUM_REQ*NUM_BITS  lane i = wdata[i*NUM_BITS +: NUM_BITS]
//   gnt    out  NUM_REQ           one-hot grant (combinational); gnt[i]=1 means lane i is written at this edge
//   q      out  NUM_BITS          shared register contents
//   q_src  out  IDX_W             index of the requester that last wrote q
//   q_vld  out  1                 1 once q has been written at least once since reset
//   lock   in   NUM_REQ           (only if DL_REG_ARB_LOCK_EN) hold the current grant
// BEHAVIOUR
//   - Reset values (rst=1 at posedge): q=0, q_src=0, q_vld=0, ptr=0, lock owner cleared.
//   - While rst=1: gnt=0 and req is ignored.
//   - Priority pointer ptr (IDX_W bits) names the highest-priority requester.
//     Search order: ptr, ptr+1, ..., wrapping modulo NUM_REQ (NUM_REQ need not be a power of 2).
//   - gnt is a pure function of req and ptr (plus lock state, when enabled).
//     gnt=0 when req=0; otherwise exactly one bit is set.
//   - Handshake: a requester holds req and wdata stable until it sees gnt.
//     gnt is same-cycle; no ready/valid skid.
//   - On a posedge with a grant to k: q<=wdata lane k, q_src<=k, q_vld<=1, ptr<=(k+1) mod NUM_REQ.
//   - On a posedge with no grant: q, q_src, q_vld and ptr all hold.
//   - Write latency: 1 cycle. q reflects the granted data the cycle after gnt.
//   - Wrap-around: grant to NUM_REQ-1 sets ptr=0.
//   - Fairness: a continuously asserted req is granted within NUM_REQ cycles.
//   - Reset mid-operation: pending requests are dropped and must be re-asserted; q returns to 0.
// CONFIGURATION
//   - Macro DL_REG_ARB_LOCK_EN.
//   - Defined: lock port exists. If lock[k]=1 when k is granted, k becomes owner.
//     While owner k keeps req[k]=1 and lock[k]=1, gnt stays at k and ptr does not advance.
//     Ownership ends when the owner deasserts req or lock, in the same cycle: normal RR resumes from ptr=(k+1) mod NUM_REQ.
//     lock[i] of a non-granted requester is ignored.
//   - Undefined: no lock port; pure round-robin every cycle.
// STRUCTURE
//   - Package dl_arb_pkg holds:
//     - function rr_pick(req, ptr) returning a one-hot grant;
//     - function onehot2idx;
//     - typedef arb_state_t {ARB_IDLE, ARB_LOCKED}, used only under the macro.
//   - Sub-module dl_rr_arb(NUM_REQ): ptr register plus grant logic.
//   - Storage: dl_reg_en instance with en = |gnt | rst and d = rst ? 0 : selected lane, giving the reset value.
// TESTING (NUM_REQ=4, NUM_BITS=32)
//   - Reset: rst=1 for 2 cycles with req=4'hF -> gnt=0; then q=0, q_vld=0, q_src=0.
//   - Single request: req=4'b0100, lane2=32'hDEADBEEF -> gnt=4'b0100 same cycle;
//     next cycle q=32'hDEADBEEF, q_src=2, q_vld=1.
//   - Rotation: req=4'hF held 5 cycles from ptr=0 -> gnt sequence 1,2,4,8,1 (one-hot); q tracks the lanes.
//   - Skip and wrap: ptr=3, req=4'b0011 -> gnt=4'b0001, then 4'b0010, then 4'b0001.
//   - Idle hold: req=0 for 3 cycles -> q, q_src, ptr unchanged; gnt=0.
//   - Lock (macro on): req=4'b0011, lock=4'b0001 at ptr=0 -> gnt=4'b0001 for 3 cycles.
//     Then drop lock[0] -> next gnt=4'b0010.

Source files
------------

// File: rtl/dl_reg_en_arb_pkg.sv
// rtl/dl_reg_en_arb_pkg.sv - shared types and grant helpers for the round-robin register arbiter
package dl_arb_pkg;

    localparam int ARB_MAX_REQ = 16;
    localparam int ARB_IDX_W   = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Two passes: requesters at or above ptr first, then the wrapped-around ones below it.
    function automatic logic [ARB_MAX_REQ-1:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0] req,
        input logic [ARB_IDX_W-1:0]   ptr,
        input int                     n
    );
        logic [ARB_MAX_REQ-1:0] gnt;
        logic                   found;
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < ARB_MAX_REQ; j++) begin
            if (!found && j < n && j >= int'(ptr) && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int j = 0; j < ARB_MAX_REQ; j++) begin
            if (!found && j < n && j < int'(ptr) && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_REQ-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int j = 0; j < ARB_MAX_REQ; j++) begin
            if (oh[j]) begin
                idx = idx | ARB_IDX_W'(j);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dl_reg_en_arb_if.sv
// rtl/dl_reg_en_arb_if.sv - requester/register bus; lock lane present only with DL_REG_ARB_LOCK_EN
interface dl_reg_en_arb_if #(
    parameter int NUM_BITS = 32,
    parameter int NUM_REQ  = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*NUM_BITS-1:0] wdata;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_BITS-1:0]         q;
    logic [IDX_W-1:0]            q_src;
    logic                        q_vld;
`ifdef DL_REG_ARB_LOCK_EN
    logic [NUM_REQ-1:0]          lock;

    modport master (output req, wdata, lock, input gnt, q, q_src, q_vld);
    modport slave  (input req, wdata, lock, output gnt, q, q_src, q_vld);
`else
    modport master (output req, wdata, input gnt, q, q_src, q_vld);
    modport slave  (input req, wdata, output gnt, q, q_src, q_vld);
`endif

endinterface

// File: rtl/dl_reg_en_arb_reg.sv
// rtl/dl_reg_en_arb_reg.sv - plain enabled register; reset arrives through en/d
module dl_reg_en #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dl_reg_en_arb_rr.sv
// rtl/dl_reg_en_arb_rr.sv - round-robin pointer and grant logic; owner lock under DL_REG_ARB_LOCK_EN
module dl_rr_arb
    import dl_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
`ifdef DL_REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] i_lock,
`endif
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic [IDX_W-1:0]       r_ptr;
    logic [NUM_REQ-1:0]     w_req;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [ARB_MAX_REQ-1:0] w_req_ext;
    logic [ARB_MAX_REQ-1:0] w_gnt_ext;
    logic [ARB_MAX_REQ-1:0] w_pick;
    logic [ARB_IDX_W-1:0]   w_idx_full;
    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_ptr_nxt;

    assign w_req = i_rst ? '0 : i_req;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NUM_REQ-1:0] = w_req;
    end

    assign w_pick = rr_pick(w_req_ext, ARB_IDX_W'(r_ptr), NUM_REQ);

`ifdef DL_REG_ARB_LOCK_EN
    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic             w_hold;

    // Owner keeps the grant only while both its req and lock stay high; release takes effect this cycle.
    always_comb begin
        w_hold = (r_state == ARB_LOCKED) && w_req[r_owner] && i_lock[r_owner];
        w_gnt  = w_pick[NUM_REQ-1:0];
        if (w_hold) begin
            w_gnt          = '0;
            w_gnt[r_owner] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = ARB_IDLE;
        w_owner_nxt = r_owner;
        if (|w_gnt && i_lock[w_idx]) begin
            w_state_nxt = ARB_LOCKED;
            w_owner_nxt = w_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end
`else
    assign w_gnt = w_pick[NUM_REQ-1:0];
`endif

    always_comb begin
        w_gnt_ext              = '0;
        w_gnt_ext[NUM_REQ-1:0] = w_gnt;
    end

    assign w_idx_full = onehot2idx(w_gnt_ext);
    assign w_idx      = w_idx_full[IDX_W-1:0];
    assign w_ptr_nxt  = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // While locked the same index wins every cycle, so ptr stays at owner+1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (|w_gnt) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_idx;

endmodule

// File: rtl/dl_reg_en_arb.sv
// rtl/dl_reg_en_arb.sv - round-robin write arbiter for one shared register; lock via DL_REG_ARB_LOCK_EN
module dl_reg_en_arb
    import dl_arb_pkg::*;
#(
    parameter int NUM_BITS = 32,
    parameter int NUM_REQ  = 4
) (
    input logic            clk,
    input logic            rst,
    dl_reg_en_arb_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SW    = NUM_BITS + IDX_W + 1;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [NUM_BITS-1:0] w_lane;
    logic                w_en;
    logic [SW-1:0]       w_d;
    logic [SW-1:0]       w_q;

    dl_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (bus.req),
`ifdef DL_REG_ARB_LOCK_EN
        .i_lock    (bus.lock),
`endif
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_lane = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_lane = bus.wdata[i*NUM_BITS +: NUM_BITS];
            end
        end
    end

    // q, q_src and q_vld share one storage word; reset loads zero through the enable path.
    assign w_en = (|w_gnt) | rst;
    assign w_d  = rst ? '0 : {1'b1, w_gnt_idx, w_lane};

    dl_reg_en #(.W(SW)) u_reg (
        .i_clk (clk),
        .i_en  (w_en),
        .i_d   (w_d),
        .o_q   (w_q)
    );

    assign bus.gnt   = w_gnt;
    assign bus.q     = w_q[NUM_BITS-1:0];
    assign bus.q_src = w_q[NUM_BITS +: IDX_W];
    assign bus.q_vld = w_q[SW-1];

endmodule

// File: tb/tb_dl_reg_en_arb.sv
// tb/tb_dl_reg_en_arb.sv - directed self-checking bench for dl_reg_en_arb (lock cases with DL_REG_ARB_LOCK_EN)
module tb_dl_reg_en_arb;

    localparam int NB = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dl_reg_en_arb_if #(.NUM_BITS(NB), .NUM_REQ(NR)) bus ();

    dl_reg_en_arb #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_val(input int i);
        return 32'(32'h1111_1111 * (i + 1));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic set_lanes;
        for (int i = 0; i < NR; i++) begin
            bus.wdata[i*NB +: NB] = lane_val(i);
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = 4'hF;
`ifdef DL_REG_ARB_LOCK_EN
        bus.lock = '0;
`endif
        set_lanes();

        // reset with all requests pending
        settle();
        check_val("rst_gnt0", 32'(bus.gnt), 32'h0);
        tick();
        settle();
        check_val("rst_gnt1", 32'(bus.gnt), 32'h0);
        tick();
        rst     = 1'b0;
        bus.req = 4'h0;
        settle();
        check_val("rst_q",     bus.q,            32'h0);
        check_val("rst_q_vld", 32'(bus.q_vld),   32'h0);
        check_val("rst_q_src", 32'(bus.q_src),   32'h0);
        check_val("idle_gnt",  32'(bus.gnt),     32'h0);

        // single request on lane 2
        bus.req             = 4'b0100;
        bus.wdata[2*NB +: NB] = 32'hDEAD_BEEF;
        settle();
        check_val("single_gnt", 32'(bus.gnt), 32'h4);
        tick();
        bus.req = 4'h0;
        settle();
        check_val("single_q",     bus.q,          32'hDEAD_BEEF);
        check_val("single_q_src", 32'(bus.q_src), 32'd2);
        check_val("single_q_vld", 32'(bus.q_vld), 32'd1);

        // reset mid-operation drops requests and clears q
        set_lanes();
        rst     = 1'b1;
        bus.req = 4'hF;
        settle();
        check_val("midrst_gnt", 32'(bus.gnt), 32'h0);
        tick();
        rst     = 1'b0;
        bus.req = 4'h0;
        settle();
        check_val("midrst_q",     bus.q,          32'h0);
        check_val("midrst_q_vld", 32'(bus.q_vld), 32'h0);

        // rotation from ptr=0
        bus.req = 4'hF;
        for (int c = 0; c < 5; c++) begin
            settle();
            check_val("rot_gnt", 32'(bus.gnt), 32'(1) << (c % 4));
            tick();
            check_val("rot_q",     bus.q,          lane_val(c % 4));
            check_val("rot_q_src", 32'(bus.q_src), 32'(c % 4));
        end

        // move ptr to 3 via lane 2, then skip and wrap with req=0011
        bus.req = 4'b0100;
        settle();
        check_val("pre_wrap_gnt", 32'(bus.gnt), 32'h4);
        tick();
        bus.req = 4'b0011;
        settle();
        check_val("wrap_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        settle();
        check_val("wrap_gnt1", 32'(bus.gnt), 32'h2);
        tick();
        settle();
        check_val("wrap_gnt2", 32'(bus.gnt), 32'h1);
        tick();

        // idle hold; ptr should remain 1
        bus.req = 4'h0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_val("hold_gnt", 32'(bus.gnt), 32'h0);
            tick();
            check_val("hold_q",     bus.q,          lane_val(0));
            check_val("hold_q_src", 32'(bus.q_src), 32'd0);
            check_val("hold_q_vld", 32'(bus.q_vld), 32'd1);
        end
        bus.req = 4'hF;
        settle();
        check_val("hold_ptr_gnt", 32'(bus.gnt), 32'h2);
        tick();
        bus.req = 4'h0;

`ifdef DL_REG_ARB_LOCK_EN
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_val("lock_gnt", 32'(bus.gnt), 32'h1);
            tick();
        end
        bus.lock = 4'b0000;
        settle();
        check_val("unlock_gnt", 32'(bus.gnt), 32'h2);
        tick();
        check_val("unlock_q_src", 32'(bus.q_src), 32'd1);
        bus.req = 4'h0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
